// File: rtl/airlock_pkg.sv
// airlock_pkg: shared airlock state encoding and timing defaults
package airlock_pkg;
  typedef enum logic [2:0] {
    IDLE,
    INNER_OPEN,
    INNER_CLOSE,
    EVACUATE,
    OUTER_OPEN,
    OUTER_CLOSE,
    REPRESS,
    FAULT
  } state_t;
  localparam int DEPRESS_CYCLES_DEF = 8;
  localparam int DOOR_TIMEOUT_DEF = 16;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for one asynchronous input, resets to 0
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic meta;
  // shift the raw level through two flops before anyone uses it
  always_ff @(posedge clk) {q, meta} <= rst ? 2'b00 : {meta, d};
endmodule

// File: rtl/airlock_egress_seq.sv
// airlock_egress_seq: egress door/pump sequencer with interlocked actuator commands
module airlock_egress_seq
  import airlock_pkg::*;
#(
  parameter int DEPRESS_CYCLES = DEPRESS_CYCLES_DEF,
  parameter int DOOR_TIMEOUT = DOOR_TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic req,
  input  logic abort,
  input  logic occ,
  input  logic inner_closed,
  input  logic outer_closed,
  output logic inner_open,
  output logic outer_open,
  output logic evac,
  output logic press,
  output logic busy,
  output logic done,
  output logic fault
);
  localparam int CW = $clog2((DEPRESS_CYCLES > DOOR_TIMEOUT ? DEPRESS_CYCLES : DOOR_TIMEOUT) + 1);
  localparam logic [CW-1:0] DEP_LAST = CW'(DEPRESS_CYCLES - 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(DOOR_TIMEOUT - 1);
  logic req_s, abort_s, occ_s, inner_closed_s, outer_closed_s;
  logic cancel, cancel_nxt;
  logic [CW-1:0] cnt;
  state_t state, nxt;
  sync_2ff u_req (.clk(clk), .rst(rst), .d(req), .q(req_s));
  sync_2ff u_abort (.clk(clk), .rst(rst), .d(abort), .q(abort_s));
  sync_2ff u_occ (.clk(clk), .rst(rst), .d(occ), .q(occ_s));
  sync_2ff u_inner (.clk(clk), .rst(rst), .d(inner_closed), .q(inner_closed_s));
  sync_2ff u_outer (.clk(clk), .rst(rst), .d(outer_closed), .q(outer_closed_s));
  // next state; abort beats occupancy and dwell expiry, a closing sensor beats its timeout
  always_comb begin
    nxt = state;
    cancel_nxt = cancel;
    case (state)
      IDLE:        nxt = req_s ? INNER_OPEN : IDLE;
      INNER_OPEN: begin
        cancel_nxt = cancel | abort_s;
        nxt = (abort_s || occ_s) ? INNER_CLOSE : INNER_OPEN;
      end
      INNER_CLOSE: nxt = inner_closed_s ? (cancel ? IDLE : EVACUATE) : (cnt == TMO_LAST ? FAULT : INNER_CLOSE);
      EVACUATE: begin
        cancel_nxt = cancel | abort_s;
        nxt = abort_s ? REPRESS : (cnt == DEP_LAST ? OUTER_OPEN : EVACUATE);
      end
      OUTER_OPEN:  nxt = occ_s ? OUTER_OPEN : OUTER_CLOSE;
      OUTER_CLOSE: nxt = outer_closed_s ? REPRESS : (cnt == TMO_LAST ? FAULT : OUTER_CLOSE);
      REPRESS:     nxt = cnt == DEP_LAST ? IDLE : REPRESS;
      default:     nxt = FAULT;
    endcase
    if (nxt == IDLE) cancel_nxt = 1'b0;
  end
  // state, shared dwell/timeout counter and outputs registered from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      cancel <= 1'b0;
      {inner_open, outer_open, evac, press, busy, done, fault} <= '0;
    end else begin
      state <= nxt;
      cnt <= nxt != state ? '0 : cnt + 1'b1;
      cancel <= cancel_nxt;
      inner_open <= nxt == INNER_OPEN;
      outer_open <= nxt == OUTER_OPEN;
      evac <= nxt == EVACUATE;
      press <= nxt == REPRESS || nxt == FAULT;
      busy <= nxt != IDLE;
      done <= state == REPRESS && nxt == IDLE && !cancel;
      fault <= nxt == FAULT;
    end
  end
endmodule

// File: tb/tb_airlock_egress_seq.sv
// tb_airlock_egress_seq: directed and random checks of the egress sequencer
module tb_airlock_egress_seq;
  localparam int D = 8;
  localparam int T = 16;
  localparam int IO = 0, OO = 1, EV = 2, PR = 3, BY = 4, DN = 5, FT = 6;
  logic clk = 1'b0, rst = 1'b1, req = 1'b0, abort = 1'b0, occ = 1'b0;
  logic inner_closed = 1'b1, outer_closed = 1'b1;
  logic inner_open, outer_open, evac, press, busy, done, fault;
  logic [6:0] o;
  int compared = 0, mismatched = 0;

  always #5 clk = ~clk;

  airlock_egress_seq #(.DEPRESS_CYCLES(D), .DOOR_TIMEOUT(T)) dut (
    .clk(clk), .rst(rst), .req(req), .abort(abort), .occ(occ),
    .inner_closed(inner_closed), .outer_closed(outer_closed),
    .inner_open(inner_open), .outer_open(outer_open), .evac(evac), .press(press),
    .busy(busy), .done(done), .fault(fault)
  );

  assign o = {fault, done, busy, press, evac, outer_open, inner_open};

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_bit(input int b, input logic v, input int budget, output int n);
    n = 0;
    while (o[b] !== v && n < budget) begin
      tick(1);
      n++;
    end
  endtask

  task automatic clean();
    {req, abort, occ} = '0;
    {inner_closed, outer_closed} = 2'b11;
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(2);
  endtask

  task automatic run_to_evac(input int d);
    int n;
    req = 1'b1; occ = 1'b1; inner_closed = 1'b0; outer_closed = 1'b1;
    wait_bit(IO, 1'b1, 10, n);
    req = 1'b0;
    wait_bit(IO, 1'b0, 10, n);
    tick(d);
    inner_closed = 1'b1;
    wait_bit(EV, 1'b1, 10, n);
  endtask

  task automatic run_to_outer_close();
    int n;
    run_to_evac(0);
    wait_bit(EV, 1'b0, D + 5, n);
    outer_closed = 1'b0; occ = 1'b0;
    wait_bit(OO, 1'b0, 10, n);
  endtask

  task automatic test_reset();
    clean();
    compared++; if (o !== 7'b0) begin mismatched++; $display("FAIL reset_idle: got %b want %b", o, 7'b0); end
    run_to_evac(0);
    tick(2);
    compared++; if (evac !== 1'b1) begin mismatched++; $display("FAIL reset_setup_evac: got %b want 1", evac); end
    rst = 1'b1;
    tick(1);
    compared++; if (o !== 7'b0) begin mismatched++; $display("FAIL reset_first_edge: got %b want %b", o, 7'b0); end
    tick(1);
    rst = 1'b0;
    tick(3);
    compared++; if (o !== 7'b0) begin mismatched++; $display("FAIL reset_after: got %b want %b", o, 7'b0); end
  endtask

  task automatic test_full_egress();
    int n;
    int d1 = int'($urandom_range(0, 10));
    int d2 = int'($urandom_range(0, 10));
    clean();
    req = 1'b1; occ = 1'b1; inner_closed = 1'b0;
    wait_bit(IO, 1'b1, 10, n);
    compared++; if (n !== 3) begin mismatched++; $display("FAIL inner_open_latency: got %0d want 3", n); end
    compared++; if (busy !== 1'b1) begin mismatched++; $display("FAIL busy_rise: got %b want 1", busy); end
    req = 1'b0;
    wait_bit(IO, 1'b0, 10, n);
    compared++; if (n !== 1) begin mismatched++; $display("FAIL inner_open_width: got %0d want 1", n); end
    tick(d1);
    inner_closed = 1'b1;
    wait_bit(EV, 1'b1, 10, n);
    compared++; if (n !== 3) begin mismatched++; $display("FAIL evac_start: got %0d want 3", n); end
    wait_bit(EV, 1'b0, D + 5, n);
    compared++; if (n !== D) begin mismatched++; $display("FAIL evac_dwell: got %0d want %0d", n, D); end
    compared++; if (o !== 7'b0010010) begin mismatched++; $display("FAIL outer_open_follows: got %b want %b", o, 7'b0010010); end
    outer_closed = 1'b0; occ = 1'b0;
    wait_bit(OO, 1'b0, 10, n);
    compared++; if (n !== 3) begin mismatched++; $display("FAIL outer_close_latency: got %0d want 3", n); end
    tick(d2);
    outer_closed = 1'b1;
    wait_bit(PR, 1'b1, 10, n);
    compared++; if (n !== 3) begin mismatched++; $display("FAIL press_start: got %0d want 3", n); end
    wait_bit(PR, 1'b0, D + 5, n);
    compared++; if (n !== D) begin mismatched++; $display("FAIL press_dwell: got %0d want %0d", n, D); end
    compared++; if (o !== 7'b0100000) begin mismatched++; $display("FAIL done_pulse: got %b want %b", o, 7'b0100000); end
    tick(1);
    compared++; if (o !== 7'b0) begin mismatched++; $display("FAIL done_single: got %b want %b", o, 7'b0); end
  endtask

  task automatic test_abort(input int c);
    int n;
    clean();
    run_to_evac(0);
    tick(c - 2);
    abort = 1'b1;
    wait_bit(EV, 1'b0, D + 5, n);
    compared++; if (n !== 3) begin mismatched++; $display("FAIL abort_evac_drop c=%0d: got %0d want 3", c, n); end
    compared++; if (o !== 7'b0011000) begin mismatched++; $display("FAIL abort_to_repress c=%0d: got %b want %b", c, o, 7'b0011000); end
    abort = 1'b0;
    wait_bit(PR, 1'b0, D + 5, n);
    compared++; if (n !== D) begin mismatched++; $display("FAIL abort_press_dwell c=%0d: got %0d want %0d", c, n, D); end
    compared++; if (o !== 7'b0) begin mismatched++; $display("FAIL abort_no_done c=%0d: got %b want %b", c, o, 7'b0); end
    tick(1);
    compared++; if (done !== 1'b0) begin mismatched++; $display("FAIL abort_no_done_late c=%0d: got %b want 0", c, done); end
  endtask

  task automatic test_abort_inner();
    int n;
    clean();
    req = 1'b1; occ = 1'b0; inner_closed = 1'b0;
    wait_bit(IO, 1'b1, 10, n);
    req = 1'b0; abort = 1'b1;
    wait_bit(IO, 1'b0, 10, n);
    compared++; if (n !== 3) begin mismatched++; $display("FAIL inner_abort_close: got %0d want 3", n); end
    abort = 1'b0; inner_closed = 1'b1;
    wait_bit(BY, 1'b0, 10, n);
    compared++; if (n !== 3) begin mismatched++; $display("FAIL inner_abort_idle: got %0d want 3", n); end
    compared++; if (o !== 7'b0) begin mismatched++; $display("FAIL inner_abort_no_done: got %b want %b", o, 7'b0); end
    tick(2);
    run_to_outer_close();
    outer_closed = 1'b1;
    wait_bit(PR, 1'b1, 10, n);
    wait_bit(PR, 1'b0, D + 5, n);
    compared++; if (done !== 1'b1) begin mismatched++; $display("FAIL cancel_cleared_done: got %b want 1", done); end
  endtask

  task automatic test_door_timeout();
    int n;
    clean();
    req = 1'b1; occ = 1'b1; inner_closed = 1'b0;
    wait_bit(IO, 1'b1, 10, n);
    req = 1'b0;
    wait_bit(IO, 1'b0, 10, n);
    wait_bit(FT, 1'b1, T + 5, n);
    compared++; if (n !== T) begin mismatched++; $display("FAIL timeout_edge: got %0d want %0d", n, T); end
    compared++; if (o !== 7'b1011000) begin mismatched++; $display("FAIL fault_outputs: got %b want %b", o, 7'b1011000); end
    inner_closed = 1'b1; req = 1'b1;
    tick(20);
    compared++; if (o !== 7'b1011000) begin mismatched++; $display("FAIL fault_sticky: got %b want %b", o, 7'b1011000); end
    req = 1'b0; rst = 1'b1;
    tick(1);
    compared++; if (o !== 7'b0) begin mismatched++; $display("FAIL fault_reset: got %b want %b", o, 7'b0); end
    rst = 1'b0;
  endtask

  task automatic test_outer_boundary();
    int n;
    clean();
    run_to_outer_close();
    tick(T - 3);
    outer_closed = 1'b1;
    wait_bit(PR, 1'b1, 10, n);
    compared++; if (n !== 3) begin mismatched++; $display("FAIL boundary_sensor_wins: got %0d want 3", n); end
    compared++; if (fault !== 1'b0) begin mismatched++; $display("FAIL boundary_no_fault: got %b want 0", fault); end
    wait_bit(PR, 1'b0, D + 5, n);
    compared++; if (done !== 1'b1) begin mismatched++; $display("FAIL boundary_done: got %b want 1", done); end
    clean();
    run_to_outer_close();
    tick(T - 2);
    outer_closed = 1'b1;
    wait_bit(FT, 1'b1, 10, n);
    compared++; if (n !== 2) begin mismatched++; $display("FAIL late_sensor_fault: got %0d want 2", n); end
    compared++; if (o !== 7'b1011000) begin mismatched++; $display("FAIL late_sensor_outputs: got %b want %b", o, 7'b1011000); end
  endtask

  task automatic test_back_to_back();
    int n;
    clean();
    req = 1'b1; occ = 1'b1; inner_closed = 1'b0;
    wait_bit(IO, 1'b1, 10, n);
    wait_bit(IO, 1'b0, 10, n);
    inner_closed = 1'b1;
    wait_bit(EV, 1'b1, 10, n);
    wait_bit(EV, 1'b0, D + 5, n);
    outer_closed = 1'b0; occ = 1'b0;
    wait_bit(OO, 1'b0, 10, n);
    outer_closed = 1'b1; inner_closed = 1'b0;
    wait_bit(PR, 1'b1, 10, n);
    wait_bit(PR, 1'b0, D + 5, n);
    compared++; if (o !== 7'b0100000) begin mismatched++; $display("FAIL held_req_done: got %b want %b", o, 7'b0100000); end
    tick(1);
    compared++; if (o !== 7'b0010001) begin mismatched++; $display("FAIL held_req_restart: got %b want %b", o, 7'b0010001); end
    req = 1'b0;
  endtask

  task automatic test_interlock();
    logic [6:0] p;
    int ev_run = 0, pr_run = 0;
    clean();
    p = o;
    for (int i = 0; i < 10000; i++) begin
      req = $urandom_range(0, 3) == 0;
      abort = $urandom_range(0, 29) == 0;
      if ($urandom_range(0, 7) == 0) occ = ~occ;
      inner_closed = $urandom_range(0, 3) != 0;
      outer_closed = $urandom_range(0, 3) != 0;
      rst = $urandom_range(0, 399) == 0;
      tick(1);
      compared++; if ((inner_open & outer_open) !== 1'b0) begin mismatched++; $display("FAIL doors_both_open @%0d: got %b want 0", i, inner_open & outer_open); end
      compared++; if ((evac & press) !== 1'b0) begin mismatched++; $display("FAIL evac_and_press @%0d: got %b want 0", i, evac & press); end
      if (!busy) begin
        compared++; if (o[3:0] !== 4'b0) begin mismatched++; $display("FAIL idle_actuators @%0d: got %b want 0000", i, o[3:0]); end
      end
      if (inner_open && !p[IO]) begin
        compared++; if (p[BY] !== 1'b0) begin mismatched++; $display("FAIL restart_while_busy @%0d: got busy %b want 0", i, p[BY]); end
      end
      if (done) begin
        compared++; if (pr_run !== D) begin mismatched++; $display("FAIL done_press_run @%0d: got %0d want %0d", i, pr_run, D); end
      end
      if (p[FT] && !rst) begin
        compared++; if (fault !== 1'b1) begin mismatched++; $display("FAIL fault_exit @%0d: got %b want 1", i, fault); end
      end
      ev_run = evac ? ev_run + 1 : 0;
      pr_run = press ? pr_run + 1 : 0;
      if (ev_run > D) begin
        compared++; mismatched++; $display("FAIL evac_overrun @%0d: got %0d want <=%0d", i, ev_run, D);
      end
      p = o;
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_full_egress();
    test_full_egress();
    test_abort(int'($urandom_range(2, 6)));
    test_abort(3);
    test_abort(D - 1);
    test_abort_inner();
    test_door_timeout();
    test_outer_boundary();
    test_back_to_back();
    test_interlock();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
